hazard_interlock_unit: RTL
==========================

Name: hazard_interlock_unit

Overview:
- Pipeline interlock controller for the 5-stage core; the stall/flush counterpart to the forwarding path.
- Covers the cases forwarding cannot resolve:
  - load-use hazards, by stalling the PC and IF/ID and inserting a bubble into ID/EX;
  - data-memory wait, by freezing the whole pipeline;
  - taken branches resolved in EX, by flushing IF/ID and ID/EX.
- Keeps its own shadow copy of the EX and MEM stage destination info, so it does not depend on pipeline-register taps.

Parameters:
- REG_ADDR_W, 5, register index width.
- MEM_TIMEOUT, 255, maximum consecutive mem_busy cycles before the timeout error is raised.
- TMO_W, 8, timeout counter width; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 of the ID instruction.
- id_rs2  in  REG_ADDR_W  source register 2 of the ID instruction.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle.
- mem_busy  in  1  data memory not ready; the pipeline must hold.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold IF/ID.
- idex_bubble  out  1  load a NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- idex_flush  out  1  clear ID/EX.
- pipe_freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
- mem_timeout_err  out  1  sticky: mem_busy exceeded MEM_TIMEOUT cycles.

Behaviour:
- Clocking and reset: one clock domain, clock; reset_n asynchronous, active low.
- Reset values:
  - all outputs 0;
  - shadow registers ex_valid=0, mem_valid=0, ex_rd=0, mem_rd=0, ex_load=0;
  - state=RUN; timeout counter=0.
- Shadow pipeline, updated each edge unless frozen:
  - mem_* <= ex_*.
  - ex_* <= id_* when the ID instruction advances: id_valid, no bubble, no flush.
  - Otherwise ex_valid <= 0.
  - ex_valid requires id_regwrite, or id_is_load together with rd != 0.
- Load-use hazard, combinational:
  - Condition: ex_valid & ex_load & ex_rd != 0 & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
  - Response: pc_stall=1, ifid_stall=1, idex_bubble=1 for exactly 1 cycle. Next cycle the load has left EX, so the hazard clears and MEM→EX forwarding covers the dependency.
- Register x0 never creates a hazard.
- Branch flush: ex_branch_taken → ifid_flush=1, idex_flush=1 that cycle.
  - The branch overrides load-use: stall and bubble are forced to 0 because the ID instruction is squashed.
  - Shadow ex_valid <= 0.
- State machine:
  - RUN: normal operation; mem_busy=1 → FREEZE.
  - FREEZE: pipe_freeze=pc_stall=ifid_stall=1 and all flush/bubble outputs 0. Shadows hold. Timeout counter increments, saturating at MEM_TIMEOUT. mem_busy=0 → RUN.
  - Transitions are Mealy: pipe_freeze asserts in the same cycle mem_busy rises, and deasserts the cycle mem_busy falls.
  - Hazard and flush evaluation resume in RUN with the unchanged shadows.
- Priority, highest first: mem_busy freeze > branch flush > load-use stall.
  - A branch_taken seen during freeze is not acted on; EX holds, so it is re-presented after the freeze.
- Timeout:
  - The counter reaching MEM_TIMEOUT sets mem_timeout_err.
  - The error is cleared only by reset.
  - The counter clears on each RUN cycle.
- Reset mid-stall or mid-freeze: all outputs drop immediately (asynchronous) and the shadows are invalidated.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three 32-bit saturating output counters are added:
  - perf_loaduse_cnt: load-use stall cycles;
  - perf_flush_cnt: branch flush cycles;
  - perf_freeze_cnt: freeze cycles.
- All three reset to 0.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package core_pipe_pkg:
  - REG_ADDR_W;
  - the state encoding typedef (RUN=1'b0, FREEZE=1'b1);
  - the x0 index constant.
- One natural sub-module: hazard_shadow_stage, the valid/rd/load shadow register pair, instantiated for EX and MEM.

Test Plan:
- Load-use, rs1 path: cycle N: EX holds load rd=5; ID: uses_rs1, rs1=5 → at N, pc_stall=ifid_stall=idex_bubble=1; at N+1, all 0 and ex_valid=0.
- No-load and x0 cases: ALU op rd=5 in EX with ID rs2=5 → no stall. Load rd=0 in EX with ID rs1=0 → no stall.
- Branch over hazard: load-use condition and ex_branch_taken=1 in the same cycle → ifid_flush=idex_flush=1, idex_bubble=0, pc_stall=0.
- Freeze: mem_busy high for 3 cycles during a load-use condition → pipe_freeze=1 for exactly 3 cycles, idex_bubble=0 throughout; bubble asserts in the first cycle after mem_busy falls.
- Timeout: MEM_TIMEOUT=4, mem_busy held 6 cycles → mem_timeout_err rises after the 4th busy cycle and stays 1 after mem_busy falls, until reset_n=0.
- Async reset during freeze: reset_n low mid-cycle → pipe_freeze, pc_stall and mem_timeout_err go 0 without waiting for a clock edge; the first cycle after release has no stall.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline control blocks.
package core_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_X0     = 0;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow copy of a pipeline stage's destination info (valid, rd, load).
module hazard_shadow_stage
    import core_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = core_pipe_pkg::REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  next_valid,
    input  logic [REG_ADDR_W-1:0] next_rd,
    input  logic                  next_load,
    output logic                  valid,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  load
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            rd    <= '0;
            load  <= 1'b0;
        end else if (en) begin
            valid <= next_valid;
            rd    <= next_rd;
            load  <= next_load;
        end
    end

endmodule

// File: rtl/hazard_interlock_unit.sv
// Stall/flush/freeze interlock for the 5-stage core, with memory-wait timeout.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_interlock_unit
    import core_pipe_pkg::*;
#(
    parameter int REG_ADDR_W  = core_pipe_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  pipe_freeze,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           perf_loaduse_cnt,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_freeze_cnt,
`endif
    output logic                  mem_timeout_err
);

    localparam logic [TMO_W-1:0]      TMO_MAX = TMO_W'(MEM_TIMEOUT);
    localparam logic [REG_ADDR_W-1:0] X0      = REG_ADDR_W'(REG_X0);

    pipe_state_e           state;
    logic [TMO_W-1:0]      tmo_cnt;

    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_load;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_load;

    logic                  load_use;
    logic                  freeze;
    logic                  flush;
    logic                  stall;
    logic                  id_advance;
    logic                  id_dest_valid;

    // Combinational decisions; everything is gated by reset so outputs drop
    // as soon as reset_n falls, independent of mem_busy or branch inputs.
    always_comb begin
        load_use = ex_valid && ex_load && (ex_rd != X0) && id_valid &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
        freeze   = reset_n && mem_busy;
        flush    = reset_n && !mem_busy && ex_branch_taken;
        stall    = reset_n && !mem_busy && !ex_branch_taken && load_use;
    end

    assign pc_stall    = freeze || stall;
    assign ifid_stall  = freeze || stall;
    assign idex_bubble = stall;
    assign ifid_flush  = flush;
    assign idex_flush  = flush;
    assign pipe_freeze = freeze;

    assign id_advance    = id_valid && !stall && !flush;
    assign id_dest_valid = id_advance && (id_regwrite || (id_is_load && (id_rd != X0)));

    hazard_shadow_stage #(.REG_ADDR_W(REG_ADDR_W)) u_ex_shadow (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (!mem_busy),
        .next_valid (id_dest_valid),
        .next_rd    (id_rd),
        .next_load  (id_is_load),
        .valid      (ex_valid),
        .rd         (ex_rd),
        .load       (ex_load)
    );

    hazard_shadow_stage #(.REG_ADDR_W(REG_ADDR_W)) u_mem_shadow (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (!mem_busy),
        .next_valid (ex_valid),
        .next_rd    (ex_rd),
        .next_load  (ex_load),
        .valid      (mem_valid),
        .rd         (mem_rd),
        .load       (mem_load)
    );

    // The entry cycle (RUN with mem_busy high) already counts as a busy cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RUN;
            tmo_cnt         <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state   <= FREEZE;
                        tmo_cnt <= TMO_W'(1);
                        if (TMO_MAX <= TMO_W'(1))
                            mem_timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= '0;
                    end
                end
                FREEZE: begin
                    if (mem_busy) begin
                        if (tmo_cnt != TMO_MAX)
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_cnt >= TMO_MAX - TMO_W'(1))
                            mem_timeout_err <= 1'b1;
                    end else begin
                        state   <= RUN;
                        tmo_cnt <= '0;
                    end
                end
                default: begin
                    state   <= RUN;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_loaduse_cnt <= '0;
            perf_flush_cnt   <= '0;
            perf_freeze_cnt  <= '0;
        end else begin
            if (stall && (perf_loaduse_cnt != '1))
                perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
            if (flush && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (freeze && (perf_freeze_cnt != '1))
                perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
        end
    end
`endif

endmodule
